// File: rtl/next_op_decoder_if.sv
// Op input, sample FIFO handshake and decoded status/event outputs of next_op_decoder.
interface next_op_decoder_if #(
    parameter int ATT_CH = 2
);
    logic [23:0]         op;
    logic                op_valid;
    logic [15:0]         sample_data;
    logic                sample_valid;
    logic                sample_ready;
    logic                audio_active;
    logic                audio_22khz;
    logic                mic_active;
    logic [8*ATT_CH-1:0] att_data;
    logic [ATT_CH-1:0]   att_update;
    logic                power_on_p;
    logic                kbd_led_p;
    logic                soft_reset_p;
    logic                timeout_p;
    logic                stray_sample_p;
    logic                overflow;

    modport master (
        output op, op_valid, sample_ready,
        input  sample_data, sample_valid, audio_active, audio_22khz, mic_active,
               att_data, att_update, power_on_p, kbd_led_p, soft_reset_p,
               timeout_p, stray_sample_p, overflow
    );

    modport slave (
        input  op, op_valid, sample_ready,
        output sample_data, sample_valid, audio_active, audio_22khz, mic_active,
               att_data, att_update, power_on_p, kbd_led_p, soft_reset_p,
               timeout_p, stray_sample_p, overflow
    );
endinterface

// File: rtl/next_op_decoder.sv
// Registered NeXT sound/keyboard op decoder: event pulses, playback/mic mode,
// attenuation registers and a sample FIFO guarded by a playback inactivity timeout.
module next_op_decoder #(
    parameter int ATT_CH     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 4096
) (
    input logic              clk,
    input logic              rst,
    next_op_decoder_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W+1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_next;

    logic [7:0]        cmd, data1, data2;
    logic              is_power, is_kbd, is_start, is_end, is_sample;
    logic              is_mic_on, is_mic_off, is_soft;
    logic [ATT_CH-1:0] att_hit;

    logic [15:0]       mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic              fifo_full, push, pop, accept, drop, flush;

    logic [CNT_W-1:0]  tcnt, tcnt_next;
    logic              rate_next, timeout_next, stray_next;

    logic                audio_active_q, audio_22khz_q, mic_active_q, overflow_q, sample_valid_q;
    logic [8*ATT_CH-1:0] att_q;
    logic [ATT_CH-1:0]   att_update_q;
    logic                power_on_q, kbd_led_q, soft_reset_q, timeout_q, stray_q;
    logic                clear;

    // A registered soft reset clears everything one cycle after the ff op.
    assign clear = rst || soft_reset_q;

    always_comb begin
        cmd        = bus.op[23:16];
        data1      = bus.op[15:8];
        data2      = bus.op[7:0];
        is_power   = bus.op_valid && (cmd == 8'hc5) && (data1 == 8'hef);
        is_kbd     = bus.op_valid && (cmd == 8'hc5) && (data1 == 8'h00);
        is_start   = bus.op_valid && ((cmd == 8'h1f) || (cmd == 8'h0f));
        is_end     = bus.op_valid && ((cmd == 8'h17) || (cmd == 8'h07));
        is_sample  = bus.op_valid && (cmd == 8'hc7);
        is_mic_on  = bus.op_valid && (cmd == 8'h0b);
        is_mic_off = bus.op_valid && (cmd == 8'h03);
        is_soft    = bus.op_valid && (cmd == 8'hff);
        att_hit    = '0;
        for (int n = 0; n < ATT_CH; n++) begin
            att_hit[n] = bus.op_valid && (cmd == 8'hc4) && (data2 == 8'(n));
        end
    end

    always_comb begin
        state_next   = state;
        rate_next    = audio_22khz_q;
        tcnt_next    = '0;
        push         = 1'b0;
        flush        = 1'b0;
        timeout_next = 1'b0;
        stray_next   = 1'b0;
        if (is_start) begin
            rate_next = (cmd == 8'h1f);
        end
        case (state)
            IDLE: begin
                if (is_start) begin
                    state_next = PLAY;
                end
                stray_next = is_sample;
            end
            PLAY: begin
                // Any op that refreshes playback leaves the counter at zero.
                if (is_sample) begin
                    push = 1'b1;
                end else if (is_end) begin
                    state_next = DRAIN;
                end else if (!is_start) begin
                    if (tcnt == CNT_LAST) begin
                        state_next   = IDLE;
                        flush        = 1'b1;
                        timeout_next = 1'b1;
                    end else begin
                        tcnt_next = tcnt + CNT_ONE;
                    end
                end
            end
            DRAIN: begin
                if (is_start) begin
                    state_next = PLAY;
                end else if (!sample_valid_q) begin
                    state_next = IDLE;
                end
                stray_next = is_sample;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fifo_full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
        pop         = sample_valid_q && bus.sample_ready;
        accept      = push && (!fifo_full || pop);
        drop        = push && fifo_full && !pop;
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (accept) wr_ptr_next = wr_ptr + PTR_ONE;
            if (pop)    rd_ptr_next = rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr[PTR_W-1:0]] <= {data1, data2};
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            tcnt           <= '0;
            sample_valid_q <= 1'b0;
            audio_active_q <= 1'b0;
            audio_22khz_q  <= 1'b0;
            mic_active_q   <= 1'b0;
            overflow_q     <= 1'b0;
            att_q          <= '0;
            att_update_q   <= '0;
            power_on_q     <= 1'b0;
            kbd_led_q      <= 1'b0;
            timeout_q      <= 1'b0;
            stray_q        <= 1'b0;
        end else begin
            wr_ptr         <= wr_ptr_next;
            rd_ptr         <= rd_ptr_next;
            tcnt           <= tcnt_next;
            sample_valid_q <= (wr_ptr_next != rd_ptr_next);
            audio_active_q <= (state_next != IDLE);
            audio_22khz_q  <= rate_next;
            if (is_mic_on) begin
                mic_active_q <= 1'b1;
            end else if (is_mic_off) begin
                mic_active_q <= 1'b0;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            for (int n = 0; n < ATT_CH; n++) begin
                if (att_hit[n]) att_q[8*n +: 8] <= data1;
            end
            att_update_q   <= att_hit;
            power_on_q     <= is_power;
            kbd_led_q      <= is_kbd;
            timeout_q      <= timeout_next;
            stray_q        <= stray_next;
        end
        // The soft reset pulse itself is never suppressed by its own clear.
        soft_reset_q <= !rst && is_soft;
    end

    assign bus.sample_data    = mem[rd_ptr[PTR_W-1:0]];
    assign bus.sample_valid   = sample_valid_q;
    assign bus.audio_active   = audio_active_q;
    assign bus.audio_22khz    = audio_22khz_q;
    assign bus.mic_active     = mic_active_q;
    assign bus.att_data       = att_q;
    assign bus.att_update     = att_update_q;
    assign bus.power_on_p     = power_on_q;
    assign bus.kbd_led_p      = kbd_led_q;
    assign bus.soft_reset_p   = soft_reset_q;
    assign bus.timeout_p      = timeout_q;
    assign bus.stray_sample_p = stray_q;
    assign bus.overflow       = overflow_q;
endmodule

// File: tb/tb_next_op_decoder.sv
// Scoreboard bench for next_op_decoder: directed scenarios, then random ops,
// every cycle checked against a queue-based behavioural model.
module tb_next_op_decoder;
    localparam int ATT_CH     = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    next_op_decoder_if #(.ATT_CH(ATT_CH)) bus ();

    next_op_decoder #(.ATT_CH(ATT_CH), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [4:0]          status;  // active, rate, mic, overflow, valid
        logic [15:0]         head;
        logic [8*ATT_CH-1:0] att;
        logic [ATT_CH+4:0]   pulses;  // att_update, power, kbd, soft, timeout, stray
    } exp_t;

    typedef enum {M_IDLE, M_PLAY, M_DRAIN} mode_t;

    exp_t        exp_q[$];
    mode_t       m_mode;
    logic [15:0] m_fifo[$];
    bit          m_rate, m_mic, m_ovf, m_srst;
    logic [7:0]  m_att[ATT_CH];
    int          m_quiet;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, want);
        end
    endtask

    // Behavioural model: advances one clock edge and queues the expected outputs.
    task automatic model_step(input bit r, input logic [23:0] o, input bit v, input bit rdy);
        logic [7:0]        c, d1, d2;
        bit                p_power, p_kbd, p_soft, p_to, p_stray;
        bit                start, stop, smp, was_empty, was_full, popped;
        logic [ATT_CH-1:0] upd;
        exp_t              e;
        c = o[23:16]; d1 = o[15:8]; d2 = o[7:0];
        p_power = 0; p_kbd = 0; p_to = 0; p_stray = 0; upd = '0;
        p_soft  = v && !r && (c == 8'hff);
        if (r || m_srst) begin
            m_mode = M_IDLE;
            m_fifo.delete();
            m_rate = 0; m_mic = 0; m_ovf = 0; m_quiet = 0;
            foreach (m_att[i]) m_att[i] = 8'h00;
        end else begin
            start   = v && (c == 8'h0f || c == 8'h1f);
            stop    = v && (c == 8'h07 || c == 8'h17);
            smp     = v && (c == 8'hc7);
            p_power = v && (c == 8'hc5) && (d1 == 8'hef);
            p_kbd   = v && (c == 8'hc5) && (d1 == 8'h00);
            for (int n = 0; n < ATT_CH; n++) begin
                if (v && c == 8'hc4 && int'(d2) == n) begin
                    m_att[n] = d1;
                    upd[n]   = 1'b1;
                end
            end
            if (v && c == 8'h0b) m_mic = 1;
            if (v && c == 8'h03) m_mic = 0;
            if (start) m_rate = (c == 8'h1f);
            was_empty = (m_fifo.size() == 0);
            was_full  = (m_fifo.size() == FIFO_DEPTH);
            popped    = !was_empty && rdy;
            if (popped) void'(m_fifo.pop_front());
            case (m_mode)
                M_IDLE: begin
                    if (start) begin m_mode = M_PLAY; m_quiet = 0; end
                    p_stray = smp;
                end
                M_PLAY: begin
                    if (smp) begin
                        m_quiet = 0;
                        if (!was_full || popped) m_fifo.push_back({d1, d2});
                        else m_ovf = 1;
                    end else if (start) begin
                        m_quiet = 0;
                    end else if (stop) begin
                        m_mode = M_DRAIN;
                    end else if (m_quiet == TIMEOUT - 1) begin
                        m_mode = M_IDLE; m_fifo.delete(); p_to = 1; m_quiet = 0;
                    end else begin
                        m_quiet++;
                    end
                end
                M_DRAIN: begin
                    if (start) begin m_mode = M_PLAY; m_quiet = 0; end
                    else if (was_empty) m_mode = M_IDLE;
                    p_stray = smp;
                end
                default: ;
            endcase
        end
        m_srst   = p_soft;
        e.status = {m_mode != M_IDLE, m_rate, m_mic, m_ovf, m_fifo.size() != 0};
        e.head   = (m_fifo.size() != 0) ? m_fifo[0] : 16'h0000;
        for (int i = 0; i < ATT_CH; i++) e.att[8*i +: 8] = m_att[i];
        e.pulses = {upd, p_power, p_kbd, p_soft, p_to, p_stray};
        exp_q.push_back(e);
    endtask

    task automatic step(input bit r, input logic [23:0] o, input bit v, input bit rdy);
        @(negedge clk);
        rst              = r;
        bus.op           = o;
        bus.op_valid     = v;
        bus.sample_ready = rdy;
        model_step(r, o, v, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 24'h0, 1'b0, 1'b0);
        step(1'b1, 24'h0, 1'b0, 1'b0);
    endtask

    function automatic logic [23:0] rand_op();
        int          sel;
        logic [15:0] d;
        sel = $urandom_range(0, 99);
        d   = 16'($urandom);
        if (sel < 35)      return {8'hc7, d};
        else if (sel < 45) return {($urandom_range(0, 1) != 0) ? 8'h1f : 8'h0f, d};
        else if (sel < 53) return {($urandom_range(0, 1) != 0) ? 8'h17 : 8'h07, d};
        else if (sel < 63) return {8'hc4, d[15:8], 8'($urandom_range(0, 3))};
        else if (sel < 68) return {8'hc5, 8'hef, d[7:0]};
        else if (sel < 73) return {8'hc5, 8'h00, d[7:0]};
        else if (sel < 76) return {8'hc5, d};
        else if (sel < 82) return {8'h0b, d};
        else if (sel < 88) return {8'h03, d};
        else if (sel < 90) return {8'hff, d};
        else               return 24'($urandom);
    endfunction

    // Monitor: compares the DUT against the oldest queued expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                cmp("status", 32'({bus.audio_active, bus.audio_22khz, bus.mic_active,
                                   bus.overflow, bus.sample_valid}), 32'(e.status));
                cmp("pulses", 32'({bus.att_update, bus.power_on_p, bus.kbd_led_p,
                                   bus.soft_reset_p, bus.timeout_p, bus.stray_sample_p}),
                    32'(e.pulses));
                cmp("att_data", 32'(bus.att_data), 32'(e.att));
                if (e.status[0]) cmp("head", 32'(bus.sample_data), 32'(e.head));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first;
        rst = 1'b1; bus.op = 24'h0; bus.op_valid = 1'b0; bus.sample_ready = 1'b0;

        // Basic playback and in-order pops.
        do_reset();
        step(0, 24'h0f0000, 1, 0);
        step(0, 24'hc71234, 1, 0);
        step(0, 24'hc75678, 1, 0);
        step(0, 24'hc79abc, 1, 0);
        cmp("t1_head", 32'(bus.sample_data), 32'h1234);
        cmp("t1_valid", 32'(bus.sample_valid), 32'h1);
        repeat (4) step(0, 24'h0, 0, 1);

        // Overflow with a full FIFO.
        do_reset();
        step(0, 24'h0f0000, 1, 0);
        for (int k = 1; k <= 6; k++) step(0, {8'hc7, 16'(k)}, 1, 0);
        cmp("t2_overflow", 32'(bus.overflow), 32'h1);
        cmp("t2_head", 32'(bus.sample_data), 32'h0001);
        step(0, 24'h0, 0, 1);
        cmp("t2_next_head", 32'(bus.sample_data), 32'h0002);

        // 22 kHz start, drain, stray sample while draining.
        do_reset();
        step(0, 24'h1f0000, 1, 0);
        step(0, 24'hc7aaaa, 1, 0);
        step(0, 24'hc7bbbb, 1, 0);
        step(0, 24'h170000, 1, 0);
        cmp("t3_rate", 32'(bus.audio_22khz), 32'h1);
        step(0, 24'hc7cccc, 1, 0);
        cmp("t3_stray", 32'(bus.stray_sample_p), 32'h1);
        step(0, 24'h0, 0, 1);
        step(0, 24'h0, 0, 1);
        cmp("t3_active_after_pops", 32'(bus.audio_active), 32'h1);
        step(0, 24'h0, 0, 1);
        cmp("t3_idle", 32'(bus.audio_active), 32'h0);

        // Timeout latency, then a sample op rescuing the final cycle.
        do_reset();
        step(0, 24'h0f0000, 1, 0);
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            step(0, 24'h0, 0, 0);
            if (bus.timeout_p && first == 0) first = k;
        end
        cmp("t4_timeout_cycle", 32'(first), 32'(TIMEOUT));
        step(0, 24'h0f0000, 1, 0);
        repeat (TIMEOUT - 1) step(0, 24'h0, 0, 0);
        step(0, 24'hc7beef, 1, 0);
        cmp("t4_sample_wins", 32'({bus.audio_active, bus.sample_valid, bus.timeout_p}), 32'b110);

        // Attenuation registers.
        do_reset();
        step(0, 24'hc43c00, 1, 0);
        cmp("t5_update0", 32'(bus.att_update), 32'h1);
        step(0, 24'hc45501, 1, 0);
        step(0, 24'hc47702, 1, 0);
        step(0, 24'hc43c05, 1, 0);
        cmp("t5_att", 32'(bus.att_data), 32'h553c);

        // Mic on, then soft reset with samples queued.
        do_reset();
        step(0, 24'h0f0000, 1, 0);
        step(0, 24'hc71111, 1, 0);
        step(0, 24'hc72222, 1, 0);
        step(0, 24'h0b0000, 1, 0);
        step(0, 24'hff0000, 1, 0);
        cmp("t6_soft_pulse", 32'({bus.soft_reset_p, bus.mic_active}), 32'b11);
        step(0, 24'h0, 0, 1);
        cmp("t6_all_reset", 32'({bus.audio_active, bus.audio_22khz, bus.mic_active, bus.overflow,
                                 bus.sample_valid, bus.att_data, bus.att_update, bus.power_on_p,
                                 bus.kbd_led_p, bus.soft_reset_p, bus.timeout_p,
                                 bus.stray_sample_p}), 32'h0);

        // Random traffic with occasional silent stretches to provoke timeouts.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                repeat (20) step(0, 24'($urandom), 0, $urandom_range(0, 1) != 0);
            end else begin
                step($urandom_range(0, 399) == 0, rand_op(), $urandom_range(0, 9) < 6,
                     $urandom_range(0, 1) != 0);
            end
        end

        step(0, 24'h0, 0, 0);
        @(posedge clk);
        #2;
        cmp("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
